// File: rtl/object_pool_pkg.sv
// Shared constants and slot state encoding for the object pool.
package object_pool_pkg;

  // Default screen geometry and coordinate width.
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int OBJ_W_DEF    = 32;
  localparam int POS_W_DEF    = 11;

  // Per-slot lifecycle.
  typedef enum logic {
    FREE   = 1'b0,
    ACTIVE = 1'b1
  } slot_state_t;

endpackage

// File: rtl/object_pool_slot.sv
// One object slot: FREE/ACTIVE state plus x/y position registers.
// An object falls by 'speed' per tick. It is freed, without a y update,
// once y+speed reaches the bottom edge. spawn_sel takes priority, so a slot
// that retires on a tick can be refilled on that same tick.
module object_pool_slot
  import object_pool_pkg::*;
#(
  parameter int POS_W    = POS_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             spawn_sel,
  input  logic [POS_W-1:0] speed,
  input  logic [POS_W-1:0] spawn_x,
  output logic             active,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y,
  output logic             retire
);

  slot_state_t      state_reg, state_next;
  logic [POS_W-1:0] x_reg, x_next;
  logic [POS_W-1:0] y_reg, y_next;
  logic [POS_W:0]   y_sum;
  logic             hits_bottom;

  // One extra bit keeps the sum from wrapping before the bottom-edge compare.
  assign y_sum       = {1'b0, y_reg} + {1'b0, speed};
  assign hits_bottom = (y_sum >= (POS_W+1)'(SCREEN_H));

  // Object leaves the screen on this tick.
  assign retire = tick & (state_reg == ACTIVE) & hits_bottom;

  // Next-state and position update for this slot.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    if (tick) begin
      if (spawn_sel) begin
        state_next = ACTIVE;
        x_next     = spawn_x;
        y_next     = '0;
      end else if (state_reg == ACTIVE) begin
        if (hits_bottom) begin
          state_next = FREE;
        end else begin
          y_next = y_sum[POS_W-1:0];
        end
      end
    end
  end

  // Slot state and position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FREE;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  assign active = (state_reg == ACTIVE);
  assign x      = x_reg;
  assign y      = y_reg;

endmodule

// File: rtl/object_pool.sv
// Multi-object manager: spawns falling objects at random x into the
// lowest-index free slot every SPAWN_INTERVAL frame ticks and retires
// objects that leave the bottom of the screen.
// Optional feature macro: OBJECT_POOL_SPEEDUP_EN (fall speed rises by one
// after every 8th spawn, up to MAX_SPEED).
module object_pool
  import object_pool_pkg::*;
#(
  parameter int NUM_OBJECTS    = 4,
  parameter int POS_W          = POS_W_DEF,
  parameter int RAND_W         = 8,
  parameter int SCREEN_W       = SCREEN_W_DEF,
  parameter int SCREEN_H       = SCREEN_H_DEF,
  parameter int OBJ_W          = OBJ_W_DEF,
  parameter int SPAWN_INTERVAL = 60,
  parameter int SPEED          = 2,
  parameter int MAX_SPEED      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         frame_tick,
  input  logic [RAND_W-1:0]            random_number,
  output logic [NUM_OBJECTS-1:0]       obj_active,
  output logic [NUM_OBJECTS*POS_W-1:0] obj_x,
  output logic [NUM_OBJECTS*POS_W-1:0] obj_y,
  output logic                         spawned,
  output logic                         missed
);

  localparam int CNT_W      = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int PROD_W     = RAND_W + POS_W;
  // Speed never starts above the ceiling.
  localparam int BASE_SPEED = (SPEED > MAX_SPEED) ? MAX_SPEED : SPEED;

  logic                   tick;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   pending_reg;
  logic                   wrap;
  logic                   spawn_req;
  logic                   any_free;
  logic                   spawn_now;
  logic [NUM_OBJECTS-1:0] free_vec;
  logic [NUM_OBJECTS-1:0] sel_vec;
  logic [NUM_OBJECTS:0]   free_below;
  logic [NUM_OBJECTS-1:0] retire_vec;
  logic [PROD_W-1:0]      x_prod;
  logic [POS_W-1:0]       spawn_x;
  logic [POS_W-1:0]       speed;
  logic                   spawned_reg;
  logic                   missed_reg;

  assign tick = frame_tick & enable;

  // Counter expiry on this tick also requests a spawn on this same tick.
  assign wrap      = (cnt_reg == CNT_W'(SPAWN_INTERVAL - 1));
  assign spawn_req = pending_reg | wrap;
  assign any_free  = |free_vec;
  assign spawn_now = tick & spawn_req & any_free;

  // Scale the random value into 0..SCREEN_W-OBJ_W-1.
  assign x_prod  = PROD_W'(random_number) * PROD_W'(SCREEN_W - OBJ_W);
  assign spawn_x = POS_W'(x_prod >> RAND_W);

  // Priority chain: a slot is picked when it is free and no lower slot is.
  assign free_below[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < NUM_OBJECTS; gi++) begin : g_slot
      // A slot retiring this tick counts as free for the spawn.
      assign free_vec[gi]     = ~obj_active[gi] | retire_vec[gi];
      assign free_below[gi+1] = free_below[gi] | free_vec[gi];
      assign sel_vec[gi]      = free_vec[gi] & ~free_below[gi] & spawn_now;

      object_pool_slot #(
        .POS_W    (POS_W),
        .SCREEN_H (SCREEN_H)
      ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .spawn_sel (sel_vec[gi]),
        .speed     (speed),
        .spawn_x   (spawn_x),
        .active    (obj_active[gi]),
        .x         (obj_x[gi*POS_W +: POS_W]),
        .y         (obj_y[gi*POS_W +: POS_W]),
        .retire    (retire_vec[gi])
      );
    end
  endgenerate

  // Spawn interval counter and the single-bit pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
    end else if (tick) begin
      cnt_reg     <= wrap ? '0 : cnt_reg + 1'b1;
      pending_reg <= spawn_req & ~any_free;
    end
  end

  // Event pulses; several retirements on one tick give a single missed pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      spawned_reg <= 1'b0;
      missed_reg  <= 1'b0;
    end else begin
      spawned_reg <= spawn_now;
      missed_reg  <= |retire_vec;
    end
  end

  assign spawned = spawned_reg;
  assign missed  = missed_reg;

`ifdef OBJECT_POOL_SPEEDUP_EN
  logic [2:0]       spawn_cnt_reg;
  logic [POS_W-1:0] speed_reg;

  // Every 8th spawn bumps the fall speed, saturating at MAX_SPEED.
  always_ff @(posedge clk) begin
    if (reset) begin
      spawn_cnt_reg <= '0;
      speed_reg     <= POS_W'(BASE_SPEED);
    end else if (spawn_now) begin
      spawn_cnt_reg <= spawn_cnt_reg + 1'b1;
      if ((spawn_cnt_reg == 3'd7) && (speed_reg < POS_W'(MAX_SPEED))) begin
        speed_reg <= speed_reg + 1'b1;
      end
    end
  end

  assign speed = speed_reg;
`else
  assign speed = POS_W'(BASE_SPEED);
`endif

endmodule
